// File: rtl/mips_pkg.sv
// Shared MIPS constants for the fetch path: NOP word, opcode/funct codes,
// register indices and small encoders that benches use to build programs.
package mips_pkg;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_AT   = 5'd1;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_A0   = 5'd4;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_T1   = 5'd9;
    localparam logic [4:0] REG_T2   = 5'd10;
    localparam logic [4:0] REG_S0   = 5'd16;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

endpackage

// File: rtl/inst_loader.sv
// Run-time program loader: auto-incrementing write pointer with a sticky
// overflow flag. Drives the write port of the instruction array.
module inst_loader #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_ovf,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx
);

    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_eff;
    logic              ovf_q, ovf_d;
    logic              in_range;

    // ld_start retargets the pointer combinationally so a same-cycle write lands at ld_base.
    assign ptr_eff  = ld_start ? ld_base : ptr_q;
    assign in_range = ptr_eff < ADDR_W'(DEPTH);
    assign wr_en    = ld_valid && in_range && !rst;
    assign wr_idx   = ptr_eff[IDX_W-1:0];

    always_comb begin
        ptr_d = ptr_eff;
        ovf_d = ld_start ? 1'b0 : ovf_q;
        if (ld_valid) begin
            if (in_range) ptr_d = ptr_eff + ADDR_W'(1);
            else          ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

    assign ld_ptr = ptr_q;
    assign ld_ovf = ovf_q;

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for the fetch stage: registered fetch port
// with flush/stall priority, address checking, and a run-time load port.
module inst_mem_sync
    import mips_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              addr_err,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] ld_ptr,
    output logic              ld_ovf
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int FIDX_W = ADDR_W - 2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [FIDX_W-1:0] fidx;
    logic              fbad;

    logic [DATA_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_loader (
        .clk      (clk),
        .rst      (rst),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_ptr   (ld_ptr),
        .ld_ovf   (ld_ovf),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx)
    );

    // Full-width range check so high address bits can never alias into the array.
    assign fidx = addr[ADDR_W-1:2];
    assign fbad = (addr[1:0] != 2'b00) || (fidx >= FIDX_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= ld_data;
    end

    always_comb begin
        inst_d  = NOP_WORD;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (flush) begin
            inst_d = NOP_WORD;
        end else if (stall) begin
            inst_d  = inst_q;
            valid_d = valid_q;
            err_d   = err_q;
        end else if (fetch_en) begin
            if (fbad) begin
                err_d = 1'b1;
            end else begin
                inst_d  = mem[fidx[IDX_W-1:0]];
                valid_d = 1'b1;
            end
        end
    end

    // Array read and write share an edge, so a colliding fetch sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q  <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = valid_q;
    assign addr_err   = err_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// Directed-vector bench for inst_mem_sync with a small DEPTH so range and
// overflow boundaries are reachable.
module tb_inst_mem_sync;
    import mips_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en, stall, flush, ld_start, ld_valid;
    logic [31:0] addr, ld_base, ld_data;
    logic [31:0] inst, ld_ptr;
    logic        inst_valid, addr_err, ld_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_mem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .stall      (stall),
        .flush      (flush),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .addr_err   (addr_err),
        .ld_start   (ld_start),
        .ld_base    (ld_base),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ptr     (ld_ptr),
        .ld_ovf     (ld_ovf)
    );

    typedef struct {
        logic        fe, st, fl;
        logic [31:0] a;
        logic        ls;
        logic [31:0] lb;
        logic        lv;
        logic [31:0] ld;
        logic [31:0] e_inst;
        logic        e_v, e_err;
        logic [31:0] e_ptr;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic fe, input logic st, input logic fl, input logic [31:0] a,
                                 input logic ls, input logic [31:0] lb, input logic lv, input logic [31:0] ld,
                                 input logic [31:0] ei, input logic ev, input logic ee,
                                 input logic [31:0] ep, input logic eo);
        vec_t v;
        v.fe = fe; v.st = st; v.fl = fl; v.a = a;
        v.ls = ls; v.lb = lb; v.lv = lv; v.ld = ld;
        v.e_inst = ei; v.e_v = ev; v.e_err = ee; v.e_ptr = ep; v.e_ovf = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ei, input logic ev, input logic ee,
                           input logic [31:0] ep, input logic eo);
        chk({tag, ".inst"},       inst,              ei);
        chk({tag, ".inst_valid"}, 32'(inst_valid),   32'(ev));
        chk({tag, ".addr_err"},   32'(addr_err),     32'(ee));
        chk({tag, ".ld_ptr"},     ld_ptr,            ep);
        chk({tag, ".ld_ovf"},     32'(ld_ovf),       32'(eo));
    endtask

    task automatic drive(input logic fe, input logic st, input logic fl, input logic [31:0] a,
                         input logic ls, input logic [31:0] lb, input logic lv, input logic [31:0] ld);
        fetch_en = fe; stall = st; flush = fl; addr = a;
        ld_start = ls; ld_base = lb; ld_valid = lv; ld_data = ld;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] N = MIPS_NOP;
    localparam logic [31:0] W1 = 32'h1111_1111, W2 = 32'h2222_2222,
                            W3 = 32'h3333_3333, W4 = 32'h4444_4444;

    initial begin
        // loader fill
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,0,0,           N,0,0,0,0));
        vecs.push_back(mkv(0,0,0,32'h0,   1,0,0,0,           N,0,0,0,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,W1,          N,0,0,1,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,W2,          N,0,0,2,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,W3,          N,0,0,3,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,W4,          N,0,0,4,0));
        // fetches
        vecs.push_back(mkv(1,0,0,32'h0,   0,0,0,0,           W1,1,0,4,0));
        vecs.push_back(mkv(1,0,0,32'h4,   0,0,0,0,           W2,1,0,4,0));
        vecs.push_back(mkv(1,0,0,32'h8,   0,0,0,0,           W3,1,0,4,0));
        vecs.push_back(mkv(1,0,0,32'hC,   0,0,0,0,           W4,1,0,4,0));
        // bad addresses
        vecs.push_back(mkv(1,0,0,32'h6,   0,0,0,0,           N,0,1,4,0));
        vecs.push_back(mkv(1,0,0,32'h40,  0,0,0,0,           N,0,1,4,0));
        vecs.push_back(mkv(1,0,0,32'h44,  0,0,0,0,           N,0,1,4,0));
        vecs.push_back(mkv(1,0,0,32'hFFFF_FFFC,0,0,0,0,      N,0,1,4,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,0,0,           N,0,0,4,0));
        // stall holds an error
        vecs.push_back(mkv(1,0,0,32'h5,   0,0,0,0,           N,0,1,4,0));
        vecs.push_back(mkv(1,1,0,32'h0,   0,0,0,0,           N,0,1,4,0));
        // stall holds a word while addr changes, then flush wins over stall
        vecs.push_back(mkv(1,0,0,32'h4,   0,0,0,0,           W2,1,0,4,0));
        vecs.push_back(mkv(1,1,0,32'h8,   0,0,0,0,           W2,1,0,4,0));
        vecs.push_back(mkv(1,1,0,32'hC,   0,0,0,0,           W2,1,0,4,0));
        vecs.push_back(mkv(0,1,0,32'h6,   0,0,0,0,           W2,1,0,4,0));
        vecs.push_back(mkv(1,1,1,32'h0,   0,0,0,0,           N,0,0,4,0));
        // read-first collision at index 2, start+valid together
        vecs.push_back(mkv(1,0,0,32'h8,   1,2,1,32'hAAAA_AAAA, W3,1,0,3,0));
        vecs.push_back(mkv(1,0,0,32'h8,   0,0,0,0,           32'hAAAA_AAAA,1,0,3,0));
        // overflow at the top of the array
        vecs.push_back(mkv(0,0,0,32'h0,   1,DEPTH-1,0,0,     N,0,0,DEPTH-1,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,32'h5555_5555, N,0,0,DEPTH,0));
        vecs.push_back(mkv(0,0,0,32'h0,   0,0,1,32'h6666_6666, N,0,0,DEPTH,1));
        vecs.push_back(mkv(1,0,0,4*(DEPTH-1),0,0,0,0,         32'h5555_5555,1,0,DEPTH,1));
        vecs.push_back(mkv(0,0,0,32'h0,   1,0,0,0,           N,0,0,0,0));
        vecs.push_back(mkv(0,0,0,32'h0,   1,20,1,32'h7777_0000, N,0,0,20,1));
        vecs.push_back(mkv(0,0,0,32'h0,   1,1,0,0,           N,0,0,1,0));
        vecs.push_back(mkv(1,0,0,32'h4,   0,0,0,0,           W2,1,0,1,0));

        rst = 1'b1;
        drive(0,0,0,0, 0,0,0,0);
        #12;
        chk_all("reset", N, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].fe, vecs[i].st, vecs[i].fl, vecs[i].a,
                  vecs[i].ls, vecs[i].lb, vecs[i].lv, vecs[i].ld);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_v, vecs[i].e_err,
                    vecs[i].e_ptr, vecs[i].e_ovf);
        end

        // asynchronous reset in the middle of a load and a stall
        drive(1,0,0,32'h4, 1,5,1,32'h7777_7777);
        step();
        chk_all("pre_rst0", W2, 1, 0, 6, 0);
        drive(1,1,0,32'h8, 0,0,1,32'h8888_8888);
        step();
        chk_all("pre_rst1", W2, 1, 0, 7, 0);
        drive(1,1,0,32'hC, 1,DEPTH,1,32'h9999_9999);
        step();
        chk_all("pre_rst2", W2, 1, 0, DEPTH, 1);
        drive(1,1,0,32'hC, 0,0,1,32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_async", N, 0, 0, 0, 0);
        step();
        chk_all("rst_held", N, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1,1,0,32'h4, 0,0,0,0);
        step();
        chk_all("post_rst_stall", N, 0, 0, 0, 0);
        drive(1,0,0,32'h14, 0,0,0,0);
        step();
        chk_all("post_rst_idx5", 32'h7777_7777, 1, 0, 0, 0);
        drive(1,0,0,32'h18, 0,0,0,0);
        step();
        chk_all("post_rst_idx6", 32'h8888_8888, 1, 0, 0, 0);
        drive(1,0,0,32'h0, 0,0,0,0);
        step();
        chk_all("post_rst_idx0", W1, 1, 0, 0, 0);
        drive(1,0,0,32'h4, 0,0,0,0);
        step();
        chk_all("post_rst_idx1", W2, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
